hit_word_decoder: RTL and testbench
===================================

Name: hit_word_decoder

Overview:
- Sits in the `clk_bx` domain directly downstream of the per-flavour serial readout receiver, which produces 27-bit hit words.
- Gray-decodes the 6-bit LE and TE fields, computes ToT, and extends the 6-bit LE stamp to a full `TS_WIDTH` timestamp against a local BCID counter.
- Buffers decoded hits in a first-word-fall-through FIFO for the DAQ interface.
- The serial link cannot be stalled, so the block never back-pressures; excess words are dropped and counted.

Parameters:
- `TS_WIDTH`, 16: width of the local BCID counter and of the extended timestamp (min 7).
- `FIFO_DEPTH`, 16: hit FIFO entries (power of 2).
- `LAT_OFFSET`, 0: BCID cycles subtracted from the local counter before timestamp extension; compensates the readout latency.

Ports:
- `clk_bx`  in  1  BX clock, 40 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `in_word`  in  27  hit word: col[26:21], te_gray[20:15], le_gray[14:9], row[8:0].
- `in_valid`  in  1  one-cycle strobe; word accepted every cycle it is high.
- `out_col`  out  6  column of FIFO head.
- `out_row`  out  9  row of FIFO head.
- `out_ts`  out  `TS_WIDTH`  extended LE timestamp of FIFO head.
- `out_tot`  out  6  ToT of FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  pop head when `out_valid && out_ready`.
- `fifo_count`  out  `$clog2(FIFO_DEPTH)+1`  current occupancy.
- `overflow_cnt`  out  16  dropped-word counter; saturates at 16'hFFFF.
- `bcid`  out  `TS_WIDTH`  local BCID counter.

Behaviour:
- Reset (synchronous, active-high, clock `clk_bx`):
  - `bcid`, `fifo_count`, `overflow_cnt`, the stage-1 valid bit and the FIFO pointers all go to 0.
  - `out_valid` = 0; `out_col`/`out_row`/`out_ts`/`out_tot` = 0.
  - Reset mid-operation discards stage-1 and all FIFO contents. An `in_valid` in the reset cycle is ignored.
- BCID counter: `bcid` increments by 1 every cycle after reset and wraps modulo 2^`TS_WIDTH`.
- Decode, cycle N (word accepted, combinational, registered into stage 1 at end of N):
  - Gray-to-binary per field: b[5] = g[5]; b[i] = b[i+1] ^ g[i].
  - ToT: `tot` = (te - le) mod 64; te == le gives 0; wrap example te = 1, le = 62 gives 3.
  - Reference value: r = `bcid` - `LAT_OFFSET` mod 2^`TS_WIDTH`, using `bcid` as seen in cycle N.
  - Timestamp: if le <= r[5:0], `ts` = {r[TS_WIDTH-1:6], le}; else `ts` = {r[TS_WIDTH-1:6]-1, le}, with the upper field mod 2^(`TS_WIDTH`-6).
- Stage 1 → FIFO write, cycle N+1:
  - The stage-1 entry is written if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise it is dropped and `overflow_cnt` increments (saturating).
- Latency: a word accepted in cycle N with the FIFO empty gives `out_valid` = 1 and head fields valid in cycle N+2.
- FIFO (FWFT): head fields are stable while `out_valid && !out_ready`.
  - Simultaneous push and pop: `fifo_count` is unchanged.
  - Pop when empty: ignored.
- Back-to-back `in_valid` every cycle is sustained; there are no bubbles and ordering is preserved.
- No state machine beyond FIFO pointer/count control; all outputs are registered except the FWFT head read.

Decomposition:
- `monopix_pkg`:
  - `t_data` (packed 27-bit hit word: col, te, le, row).
  - `t_hit` struct (col, row, ts, tot).
  - Function `gray2bin6`.
  - Field-position localparams.
- Sub-module `hit_fifo`: synchronous FWFT FIFO, parameterised width/depth, with count, full and empty outputs. The decoder instantiates it once.

Test Plan:
- Basic decode, `LAT_OFFSET` = 0: `bcid` = 0x0105 at accept; word col = 3, row = 100, le_gray = 6'b000010, te_gray = 6'b001111 → `out_valid` 2 cycles later with col = 3, row = 100, `ts` = 0x0103, `tot` = 7.
- LE wrap: `bcid` = 0x0102 at accept, le_gray = 6'b100010 (60) → `ts` = 0x00FC.
- ToT wrap: le_gray = 6'b100001 (62), te_gray = 6'b000001 (1) → `tot` = 3.
- Overflow: `out_ready` = 0, 18 consecutive `in_valid` words with row 0..17 → `fifo_count` = 16, `overflow_cnt` = 2. Then `out_ready` = 1 → rows 0..15 pop in order and `out_valid` drops.
- Full with pop: FIFO full, `out_ready` = 1, one new word → accepted, `fifo_count` stays 16, `overflow_cnt` unchanged.
- Reset mid-stream: assert `reset` for 1 cycle with 5 words buffered and 1 in stage 1 → next cycle `out_valid` = 0, `fifo_count` = 0, `bcid` = 0, `overflow_cnt` = 0.

Source files
------------

// File: rtl/monopix_pkg.sv
// Shared types and helpers for the hit-word decode path: raw word layout,
// decoded hit record and the 6-bit Gray decoder.
package monopix_pkg;

    localparam int WORD_W  = 27;
    localparam int COL_W   = 6;
    localparam int ROW_W   = 9;
    localparam int STAMP_W = 6;

    localparam int COL_LSB = 21;
    localparam int TE_LSB  = 15;
    localparam int LE_LSB  = 9;
    localparam int ROW_LSB = 0;

    localparam int TS_DEFAULT = 16;

    typedef struct packed {
        logic [COL_W-1:0]   col;
        logic [STAMP_W-1:0] te;
        logic [STAMP_W-1:0] le;
        logic [ROW_W-1:0]   row;
    } t_data;

    // Decoded hit at the default timestamp width; the decoder builds its own
    // record sized to its TS_WIDTH.
    typedef struct packed {
        logic [COL_W-1:0]      col;
        logic [ROW_W-1:0]      row;
        logic [TS_DEFAULT-1:0] ts;
        logic [STAMP_W-1:0]    tot;
    } t_hit;

    function automatic logic [5:0] gray2bin6(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/hit_fifo.sv
// Synchronous first-word-fall-through FIFO; head data reads as zero when empty.
module hit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_bx,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    // Status flags and the push/pop qualification; a full FIFO still accepts a push when a pop frees a slot.
    always_comb begin
        empty   = (count_r == (AW+1)'(0));
        full    = (count_r == (AW+1)'(DEPTH));
        rd_en_s = pop && !empty;
        wr_en_s = push && (!full || rd_en_s);
    end

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk_bx) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head read; zero when empty so the outputs are clean after reset.
    always_comb begin
        if (empty) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hit_word_decoder.sv
// Decodes serial-link hit words (Gray LE/TE, ToT, timestamp extension against
// the local BCID) and buffers them in a never-stalling FWFT FIFO.
module hit_word_decoder
    import monopix_pkg::*;
#(
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LAT_OFFSET = 0
) (
    input  logic                          clk_bx,
    input  logic                          reset,
    input  logic [WORD_W-1:0]             in_word,
    input  logic                          in_valid,
    output logic [COL_W-1:0]              out_col,
    output logic [ROW_W-1:0]              out_row,
    output logic [TS_WIDTH-1:0]           out_ts,
    output logic [STAMP_W-1:0]            out_tot,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   overflow_cnt,
    output logic [TS_WIDTH-1:0]           bcid
);

    localparam int HIT_W = COL_W + ROW_W + TS_WIDTH + STAMP_W;
    localparam logic [TS_WIDTH-1:0] LAT_W = TS_WIDTH'(LAT_OFFSET);

    typedef struct packed {
        logic [COL_W-1:0]    col;
        logic [ROW_W-1:0]    row;
        logic [TS_WIDTH-1:0] ts;
        logic [STAMP_W-1:0]  tot;
    } hit_rec_t;

    t_data               word_s;
    logic [STAMP_W-1:0]  le_bin_s;
    logic [STAMP_W-1:0]  te_bin_s;
    logic [TS_WIDTH-1:0] ref_s;
    logic [TS_WIDTH-7:0] ts_hi_s;
    hit_rec_t            dec_s;
    hit_rec_t            s1_hit_r;
    logic                s1_valid_r;
    hit_rec_t            head_s;
    logic                full_s;
    logic                empty_s;
    logic                pop_s;
    logic                drop_s;
    logic [TS_WIDTH-1:0] bcid_r;
    logic [15:0]         ovf_r;

    assign word_s = '{col: in_word[COL_LSB +: COL_W],
                      te:  in_word[TE_LSB  +: STAMP_W],
                      le:  in_word[LE_LSB  +: STAMP_W],
                      row: in_word[ROW_LSB +: ROW_W]};

    // Field decode and LE timestamp extension; an LE ahead of the reference belongs to the previous 64-BX page.
    always_comb begin
        le_bin_s = gray2bin6(word_s.le);
        te_bin_s = gray2bin6(word_s.te);
        ref_s    = bcid_r - LAT_W;
        if (le_bin_s <= ref_s[5:0]) begin
            ts_hi_s = ref_s[TS_WIDTH-1:6];
        end else begin
            ts_hi_s = ref_s[TS_WIDTH-1:6] - (TS_WIDTH-6)'(1);
        end
        dec_s.col = word_s.col;
        dec_s.row = word_s.row;
        dec_s.ts  = {ts_hi_s, le_bin_s};
        dec_s.tot = te_bin_s - le_bin_s;
    end

    // Local BCID counter.
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            bcid_r <= '0;
        end else begin
            bcid_r <= bcid_r + TS_WIDTH'(1);
        end
    end

    // Stage-1 register between decode and FIFO write.
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_hit_r   <= '0;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_hit_r <= dec_s;
            end
        end
    end

    // Drop qualification mirrors the FIFO's own push acceptance.
    always_comb begin
        pop_s  = out_ready && !empty_s;
        drop_s = s1_valid_r && full_s && !pop_s;
    end

    // Saturating dropped-word counter.
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            ovf_r <= 16'h0000;
        end else if (drop_s && (ovf_r != 16'hFFFF)) begin
            ovf_r <= ovf_r + 16'h0001;
        end
    end

    hit_fifo #(
        .WIDTH (HIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .clk_bx (clk_bx),
        .reset  (reset),
        .push   (s1_valid_r),
        .wdata  (s1_hit_r),
        .pop    (pop_s),
        .rdata  (head_s),
        .count  (fifo_count),
        .full   (full_s),
        .empty  (empty_s)
    );

    assign out_col      = head_s.col;
    assign out_row      = head_s.row;
    assign out_ts       = head_s.ts;
    assign out_tot      = head_s.tot;
    assign out_valid    = !empty_s;
    assign overflow_cnt = ovf_r;
    assign bcid         = bcid_r;

endmodule

// File: tb/tb_hit_word_decoder.sv
// Directed self-checking bench for hit_word_decoder (default parameters).
module tb_hit_word_decoder;

    logic        clk_bx = 1'b0;
    logic        reset;
    logic [26:0] in_word;
    logic        in_valid;
    logic [5:0]  out_col;
    logic [8:0]  out_row;
    logic [15:0] out_ts;
    logic [5:0]  out_tot;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fifo_count;
    logic [15:0] overflow_cnt;
    logic [15:0] bcid;

    int n_vec = 0;
    int n_err = 0;

    hit_word_decoder dut (
        .clk_bx       (clk_bx),
        .reset        (reset),
        .in_word      (in_word),
        .in_valid     (in_valid),
        .out_col      (out_col),
        .out_row      (out_row),
        .out_ts       (out_ts),
        .out_tot      (out_tot),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_count   (fifo_count),
        .overflow_cnt (overflow_cnt),
        .bcid         (bcid)
    );

    always #5 clk_bx = ~clk_bx;

    function automatic logic [26:0] mk_word(input logic [5:0] col, input logic [8:0] row,
                                            input logic [5:0] le_g, input logic [5:0] te_g);
        return {col, te_g, le_g, row};
    endfunction

    task automatic do_reset();
        @(negedge clk_bx);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk_bx);
        reset = 1'b0;
    endtask

    task automatic wait_bcid(input logic [15:0] target);
        int k = 0;
        while (bcid !== target && k < 2000) begin
            @(negedge clk_bx);
            k++;
        end
        n_vec++;
        if (bcid !== target) begin n_err++; $display("FAIL bcid_reach: got %h expected %h", bcid, target); end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        n_vec++; if (overflow_cnt !== 16'd0) begin n_err++; $display("FAIL rst_ovf: got %0d expected 0", overflow_cnt); end
        n_vec++; if ({out_col, out_row, out_ts, out_tot} !== 37'd0) begin n_err++; $display("FAIL rst_head: got %h expected 0", {out_col, out_row, out_ts, out_tot}); end
    endtask

    task automatic test_bcid();
        do_reset();
        n_vec++; if (bcid !== 16'd0) begin n_err++; $display("FAIL bcid_zero: got %h expected 0000", bcid); end
        repeat (10) @(negedge clk_bx);
        n_vec++; if (bcid !== 16'd10) begin n_err++; $display("FAIL bcid_count: got %h expected 000a", bcid); end
    endtask

    task automatic test_basic_decode();
        do_reset();
        wait_bcid(16'h0105);
        in_word = mk_word(6'd3, 9'd100, 6'b000010, 6'b001111); in_valid = 1'b1;
        @(negedge clk_bx);
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early: got %b expected 0", out_valid); end
        @(negedge clk_bx);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        n_vec++; if (out_col !== 6'd3) begin n_err++; $display("FAIL basic_col: got %0d expected 3", out_col); end
        n_vec++; if (out_row !== 9'd100) begin n_err++; $display("FAIL basic_row: got %0d expected 100", out_row); end
        n_vec++; if (out_ts !== 16'h0103) begin n_err++; $display("FAIL basic_ts: got %h expected 0103", out_ts); end
        n_vec++; if (out_tot !== 6'd7) begin n_err++; $display("FAIL basic_tot: got %0d expected 7", out_tot); end
        n_vec++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL basic_count: got %0d expected 1", fifo_count); end
        out_ready = 1'b1;
        @(negedge clk_bx);
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || out_col !== 6'd0) begin n_err++; $display("FAIL basic_pop: got valid %b col %0d expected 0 0", out_valid, out_col); end
    endtask

    task automatic test_le_wrap();
        do_reset();
        wait_bcid(16'h0102);
        in_word = mk_word(6'd0, 9'd0, 6'b100010, 6'b100010); in_valid = 1'b1;
        @(negedge clk_bx);
        in_valid = 1'b0;
        @(negedge clk_bx);
        n_vec++; if (out_ts !== 16'h00FC) begin n_err++; $display("FAIL lewrap_ts: got %h expected 00fc", out_ts); end
        n_vec++; if (out_tot !== 6'd0) begin n_err++; $display("FAIL lewrap_tot_eq: got %0d expected 0", out_tot); end
    endtask

    task automatic test_tot_wrap();
        do_reset();
        wait_bcid(16'h0200);
        in_word = mk_word(6'd63, 9'd511, 6'b100001, 6'b000001); in_valid = 1'b1;
        @(negedge clk_bx);
        in_valid = 1'b0;
        @(negedge clk_bx);
        n_vec++; if (out_tot !== 6'd3) begin n_err++; $display("FAIL totwrap_tot: got %0d expected 3", out_tot); end
        n_vec++; if (out_ts !== 16'h01FE) begin n_err++; $display("FAIL totwrap_ts: got %h expected 01fe", out_ts); end
        n_vec++; if (out_col !== 6'd63 || out_row !== 9'd511) begin n_err++; $display("FAIL totwrap_colrow: got %0d/%0d expected 63/511", out_col, out_row); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i >= 2 && i < 6) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_row !== 9'(10 + i - 2)) begin
                    n_err++; $display("FAIL b2b_row%0d: got valid %b row %0d expected 1 %0d", i, out_valid, out_row, 10 + i - 2);
                end
            end
            if (i == 6) begin
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
            end
            if (i < 4) begin
                in_word = mk_word(6'd1, 9'(10 + i), 6'd0, 6'd0); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk_bx);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            in_word = mk_word(6'd2, 9'(i), 6'd0, 6'd0); in_valid = 1'b1;
            @(negedge clk_bx);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk_bx);
        n_vec++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d expected 16", fifo_count); end
        n_vec++; if (overflow_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_cnt: got %0d expected 2", overflow_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_row !== 9'(i)) begin
                n_err++; $display("FAIL ovf_pop%0d: got valid %b row %0d expected 1 %0d", i, out_valid, out_row, i);
            end
            @(negedge clk_bx);
        end
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin n_err++; $display("FAIL ovf_empty: got valid %b count %0d expected 0 0", out_valid, fifo_count); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 6; i++) begin
            in_word = mk_word(6'd4, 9'(20 + i), 6'd0, 6'd0); in_valid = 1'b1;
            @(negedge clk_bx);
        end
        n_vec++; if (fifo_count !== 5'd5) begin n_err++; $display("FAIL mid_pre_count: got %0d expected 5", fifo_count); end
        reset = 1'b1; in_word = mk_word(6'd5, 9'd99, 6'd0, 6'd0); in_valid = 1'b1;
        @(negedge clk_bx);
        reset = 1'b0; in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
        n_vec++; if (bcid !== 16'd0) begin n_err++; $display("FAIL mid_bcid: got %h expected 0000", bcid); end
        n_vec++; if (overflow_cnt !== 16'd0) begin n_err++; $display("FAIL mid_ovf: got %0d expected 0", overflow_cnt); end
        repeat (3) @(negedge clk_bx);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_discard: got %b expected 0", out_valid); end
    endtask

    task automatic test_full_with_pop();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            in_word = (i < 16) ? mk_word(6'd6, 9'(30 + i), 6'd0, 6'd0) : mk_word(6'd7, 9'h1AB, 6'd0, 6'd0);
            in_valid = 1'b1;
            @(negedge clk_bx);
        end
        in_valid = 1'b0;
        n_vec++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL fwp_full: got %0d expected 16", fifo_count); end
        out_ready = 1'b1;
        @(negedge clk_bx);
        out_ready = 1'b0;
        n_vec++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL fwp_count: got %0d expected 16", fifo_count); end
        n_vec++; if (overflow_cnt !== 16'd0) begin n_err++; $display("FAIL fwp_ovf: got %0d expected 0", overflow_cnt); end
        out_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            n_vec++;
            if (out_row !== ((i < 16) ? 9'(30 + i) : 9'h1AB)) begin
                n_err++; $display("FAIL fwp_order%0d: got %h expected %h", i, out_row, (i < 16) ? 9'(30 + i) : 9'h1AB);
            end
            @(negedge clk_bx);
        end
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fwp_drain: got %b expected 0", out_valid); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_word = 27'd0; out_ready = 1'b0;
        test_reset();
        test_bcid();
        test_basic_decode();
        test_le_wrap();
        test_tot_wrap();
        test_back_to_back();
        test_overflow();
        test_reset_midstream();
        test_full_with_pop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
